commit_trace_serializer: RTL and testbench
==========================================

# commit_trace_serializer

Serializes the 4-wide BOOM commit bundle into an ordered, one-retire-per-cycle trace stream for the co-simulation checker in the core harness. It sits between the core's commit/CSR-write debug taps and a single-lane valid/ready trace consumer. It compacts the valid slots of each commit cycle into program order, buffers them in a FIFO, and tags each retire with a sequence number. Commit cannot be stalled, so overflow is detected, counted and flagged rather than back-pressured.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 8
- XLEN, 64, scalar write-data width
- ADDR_BITS, 40, debug PC width
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- commit_arch_valids_k  in  1  slot k retires this cycle (k = 0..3)
- commit_uops_k_ldst  in  5  slot k logical destination
- commit_uops_k_dst_rtype  in  3  slot k destination register type
- commit_uops_k_debug_pc  in  ADDR_BITS  slot k PC
- commit_uops_k_debug_inst  in  32  slot k instruction word
- commit_uops_k_debug_wdata  in  XLEN  slot k write data
- csrwr_cmd  in  3  CSR command; nonzero = CSR access this cycle
- csrwr_addr  in  12  CSR address
- csrwr_wdata  in  64  CSR write data
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_seq  out  64  retire sequence number
- out_pc, out_inst, out_ldst, out_rtype, out_wdata  out  as inputs  head entry fields
- out_csr_valid, out_csr_addr, out_csr_wdata  out  1/12/64  CSR event attached to the entry
- overflow  out  1  sticky: at least one commit group dropped
- drop_cnt  out  32  number of retires dropped, saturating
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Each cycle: n = popcount(commit_arch_valids_0..3). Valid slots are compacted in ascending slot order, so slot 0 is the oldest, and written to tail, tail+1, …
- Admission is all-or-nothing per cycle: a group of n is written only if free slots ≥ n, where free = DEPTH − level + (1 if a pop happens this cycle). Otherwise the entire group is dropped, overflow is set to 1, and drop_cnt += n (saturating at 0xFFFFFFFF).
- Sequence counter seq (64-bit) increments by the number of accepted retires. Each entry gets seq+i. Dropped retires do not consume sequence numbers, so the consumer detects loss via overflow/drop_cnt.
- Pop occurs when out_valid && out_ready. Head advances by 1.
- Pointers wrap modulo DEPTH. Level is tracked separately, so full (level = DEPTH) and empty (level = 0) are unambiguous.
- Push and pop in the same cycle are legal at any level, including full with n ≥ 1, because the pop credit counts toward free.
- n = 0: no write, no counter change.
- Out-of-order or gapped valid patterns (e.g. slots 1 and 3 only) are legal. Compaction is by position, not by assumption of contiguity.
- overflow and drop_cnt clear only on reset.

## Timing
- Reset (reset low, asynchronous): level = 0, head = tail = 0, seq = 0, out_valid = 0, overflow = 0, drop_cnt = 0, all out_* data = 0.
- Latency: a retire captured at edge N is presented at the head, with out_valid high, from cycle N+1 when the FIFO was empty. No combinational path from commit inputs to out_*.
- out_* fields are driven from FIFO storage at the head pointer. They are stable while out_valid && !out_ready.
- Throughput: 1 retire/cycle out, up to 4/cycle in.
- Reset asserted mid-stream discards all buffered entries immediately.

## Configuration
- COMMIT_TRACE_CSR_EN defined: a cycle with csrwr_cmd ≠ 0 and n ≥ 1 attaches csr addr/wdata to the youngest accepted retire of that group, with out_csr_valid = 1 on that entry. A CSR event with n = 0 is discarded. If the group is dropped, its CSR event is dropped with it.
- Not defined: no CSR storage is built; out_csr_valid, out_csr_addr and out_csr_wdata are tied to 0.

## Test plan
- Single retire: slot 0 only, PC 0x80000000, out_ready = 1 -> next cycle out_valid = 1, out_pc = 0x80000000, out_seq = 0; one cycle later out_valid = 0.
- Gapped group: slots 1 and 3 valid, PCs 0x104 and 0x10C -> two consecutive outputs in order 0x104 then 0x10C, seq 0 then 1.
- Sustained 4-wide commits for 8 cycles, out_ready = 1, DEPTH = 16 -> overflow = 1 on the first cycle where free < 4; drop_cnt equals 4 × the number of refused groups; out_seq is contiguous with no gaps.
- Full FIFO (level = 16), n = 1, out_ready = 1 -> group accepted, level stays 16, no overflow.
- Backpressure: out_ready = 0 for 5 cycles with the head valid -> out_* fields held constant; releasing out_ready drains in order.
- With COMMIT_TRACE_CSR_EN: slots 0 and 2 valid, csrwr_cmd = 1, addr 0x300, wdata 0x8 -> only the slot 2 entry shows out_csr_valid = 1, out_csr_addr = 0x300, out_csr_wdata = 0x8. Mid-stream reset low -> out_valid = 0 immediately.

Source files
------------

// File: rtl/commit_trace_serializer.sv
// Compacts up to four commit slots per cycle into a FIFO and replays them one retire per cycle.
// Optional CSR event tagging is built when COMMIT_TRACE_CSR_EN is defined.
module commit_trace_serializer #(
    parameter int DEPTH     = 16,
    parameter int XLEN      = 64,
    parameter int ADDR_BITS = 40
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         commit_arch_valids_0,
    input  logic                         commit_arch_valids_1,
    input  logic                         commit_arch_valids_2,
    input  logic                         commit_arch_valids_3,
    input  logic [4:0]                   commit_uops_0_ldst,
    input  logic [4:0]                   commit_uops_1_ldst,
    input  logic [4:0]                   commit_uops_2_ldst,
    input  logic [4:0]                   commit_uops_3_ldst,
    input  logic [2:0]                   commit_uops_0_dst_rtype,
    input  logic [2:0]                   commit_uops_1_dst_rtype,
    input  logic [2:0]                   commit_uops_2_dst_rtype,
    input  logic [2:0]                   commit_uops_3_dst_rtype,
    input  logic [ADDR_BITS-1:0]         commit_uops_0_debug_pc,
    input  logic [ADDR_BITS-1:0]         commit_uops_1_debug_pc,
    input  logic [ADDR_BITS-1:0]         commit_uops_2_debug_pc,
    input  logic [ADDR_BITS-1:0]         commit_uops_3_debug_pc,
    input  logic [31:0]                  commit_uops_0_debug_inst,
    input  logic [31:0]                  commit_uops_1_debug_inst,
    input  logic [31:0]                  commit_uops_2_debug_inst,
    input  logic [31:0]                  commit_uops_3_debug_inst,
    input  logic [XLEN-1:0]              commit_uops_0_debug_wdata,
    input  logic [XLEN-1:0]              commit_uops_1_debug_wdata,
    input  logic [XLEN-1:0]              commit_uops_2_debug_wdata,
    input  logic [XLEN-1:0]              commit_uops_3_debug_wdata,
    input  logic [2:0]                   csrwr_cmd,
    input  logic [11:0]                  csrwr_addr,
    input  logic [63:0]                  csrwr_wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_seq,
    output logic [ADDR_BITS-1:0]         out_pc,
    output logic [31:0]                  out_inst,
    output logic [4:0]                   out_ldst,
    output logic [2:0]                   out_rtype,
    output logic [XLEN-1:0]              out_wdata,
    output logic                         out_csr_valid,
    output logic [11:0]                  out_csr_addr,
    output logic [63:0]                  out_csr_wdata,
    output logic                         overflow,
    output logic [31:0]                  drop_cnt,
    output logic [$clog2(DEPTH):0]       fifo_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = LW + 1;

    logic [3:0]           valid_s;
    logic [4:0]           ldst_s  [4];
    logic [2:0]           rtype_s [4];
    logic [ADDR_BITS-1:0] pc_s    [4];
    logic [31:0]          inst_s  [4];
    logic [XLEN-1:0]      wdata_s [4];

    assign valid_s    = {commit_arch_valids_3, commit_arch_valids_2,
                         commit_arch_valids_1, commit_arch_valids_0};
    assign ldst_s[0]  = commit_uops_0_ldst;
    assign ldst_s[1]  = commit_uops_1_ldst;
    assign ldst_s[2]  = commit_uops_2_ldst;
    assign ldst_s[3]  = commit_uops_3_ldst;
    assign rtype_s[0] = commit_uops_0_dst_rtype;
    assign rtype_s[1] = commit_uops_1_dst_rtype;
    assign rtype_s[2] = commit_uops_2_dst_rtype;
    assign rtype_s[3] = commit_uops_3_dst_rtype;
    assign pc_s[0]    = commit_uops_0_debug_pc;
    assign pc_s[1]    = commit_uops_1_debug_pc;
    assign pc_s[2]    = commit_uops_2_debug_pc;
    assign pc_s[3]    = commit_uops_3_debug_pc;
    assign inst_s[0]  = commit_uops_0_debug_inst;
    assign inst_s[1]  = commit_uops_1_debug_inst;
    assign inst_s[2]  = commit_uops_2_debug_inst;
    assign inst_s[3]  = commit_uops_3_debug_inst;
    assign wdata_s[0] = commit_uops_0_debug_wdata;
    assign wdata_s[1] = commit_uops_1_debug_wdata;
    assign wdata_s[2] = commit_uops_2_debug_wdata;
    assign wdata_s[3] = commit_uops_3_debug_wdata;

    logic [PW-1:0]        head_r;
    logic [PW-1:0]        tail_r;
    logic [LW-1:0]        level_r;
    logic [63:0]          head_seq_r;
    logic                 overflow_r;
    logic [31:0]          drop_cnt_r;

    logic [ADDR_BITS-1:0] mem_pc_r    [DEPTH];
    logic [31:0]          mem_inst_r  [DEPTH];
    logic [4:0]           mem_ldst_r  [DEPTH];
    logic [2:0]           mem_rtype_r [DEPTH];
    logic [XLEN-1:0]      mem_wdata_r [DEPTH];

    logic [2:0]           off_s  [4];
    logic [PW-1:0]        widx_s [4];
    logic [2:0]           n_s;
    logic [FW-1:0]        free_s;
    logic                 pop_s;
    logic                 accept_s;
    logic                 drop_s;
    logic [32:0]          drop_sum_s;
    logic                 head_valid_s;

    // Slot compaction: each valid slot lands at tail plus the count of older valid slots.
    always_comb begin
        n_s = 3'd0;
        for (int k = 0; k < 4; k++) begin
            off_s[k]  = n_s;
            widx_s[k] = tail_r + PW'(n_s);
            n_s       = n_s + {2'b00, valid_s[k]};
        end
    end

    // Admission control: the whole group fits (counting this cycle's pop) or is dropped.
    always_comb begin
        head_valid_s = (level_r != {LW{1'b0}});
        pop_s        = head_valid_s && out_ready;
        free_s       = FW'(DEPTH) - {1'b0, level_r} + {{(FW-1){1'b0}}, pop_s};
        accept_s     = (n_s != 3'd0) && (FW'(n_s) <= free_s);
        drop_s       = (n_s != 3'd0) && !accept_s;
        drop_sum_s   = {1'b0, drop_cnt_r} + {30'd0, n_s};
    end

    // Pointer, occupancy, sequence and loss bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            level_r    <= {LW{1'b0}};
            head_seq_r <= 64'd0;
            overflow_r <= 1'b0;
            drop_cnt_r <= 32'd0;
        end else begin
            level_r <= level_r + (accept_s ? LW'(n_s) : {LW{1'b0}})
                               - {{(LW-1){1'b0}}, pop_s};
            if (accept_s) begin
                tail_r <= tail_r + PW'(n_s);
            end else begin
                tail_r <= tail_r;
            end
            // Accepted retires get contiguous sequence numbers and leave in order,
            // so the head's sequence number is simply the count of pops so far.
            if (pop_s) begin
                head_r     <= head_r + {{(PW-1){1'b0}}, 1'b1};
                head_seq_r <= head_seq_r + 64'd1;
            end else begin
                head_r     <= head_r;
                head_seq_r <= head_seq_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                drop_cnt_r <= drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
            end else begin
                overflow_r <= overflow_r;
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Entry storage; contents are only observable through the valid-masked head read.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (accept_s && valid_s[k]) begin
                mem_pc_r[widx_s[k]]    <= pc_s[k];
                mem_inst_r[widx_s[k]]  <= inst_s[k];
                mem_ldst_r[widx_s[k]]  <= ldst_s[k];
                mem_rtype_r[widx_s[k]] <= rtype_s[k];
                mem_wdata_r[widx_s[k]] <= wdata_s[k];
            end
        end
    end

`ifdef COMMIT_TRACE_CSR_EN
    logic        mem_csr_v_r [DEPTH];
    logic [11:0] mem_csr_a_r [DEPTH];
    logic [63:0] mem_csr_d_r [DEPTH];

    // CSR event rides on the youngest retire of an accepted group.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (accept_s && valid_s[k]) begin
                mem_csr_v_r[widx_s[k]] <= (csrwr_cmd != 3'd0) && (off_s[k] == n_s - 3'd1);
                mem_csr_a_r[widx_s[k]] <= csrwr_addr;
                mem_csr_d_r[widx_s[k]] <= csrwr_wdata;
            end
        end
    end

    assign out_csr_valid = head_valid_s && mem_csr_v_r[head_r];
    assign out_csr_addr  = out_csr_valid ? mem_csr_a_r[head_r] : 12'd0;
    assign out_csr_wdata = out_csr_valid ? mem_csr_d_r[head_r] : 64'd0;
`else
    logic unused_csr_s;
    logic unused_off_s;
    assign unused_csr_s  = ^{csrwr_cmd, csrwr_addr, csrwr_wdata};
    assign unused_off_s  = ^{off_s[0], off_s[1], off_s[2], off_s[3]};
    assign out_csr_valid = 1'b0;
    assign out_csr_addr  = 12'd0;
    assign out_csr_wdata = 64'd0;
`endif

    assign out_valid  = head_valid_s;
    assign out_seq    = head_valid_s ? head_seq_r : 64'd0;
    assign out_pc     = head_valid_s ? mem_pc_r[head_r] : {ADDR_BITS{1'b0}};
    assign out_inst   = head_valid_s ? mem_inst_r[head_r] : 32'd0;
    assign out_ldst   = head_valid_s ? mem_ldst_r[head_r] : 5'd0;
    assign out_rtype  = head_valid_s ? mem_rtype_r[head_r] : 3'd0;
    assign out_wdata  = head_valid_s ? mem_wdata_r[head_r] : {XLEN{1'b0}};
    assign overflow   = overflow_r;
    assign drop_cnt   = drop_cnt_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed plus randomized bench for commit_trace_serializer against a queue-based reference model.
module tb_commit_trace_serializer;
    localparam int DEPTH = 16;
    localparam int XLEN = 64;
    localparam int ADDR_BITS = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  v = 4'd0;
    logic [4:0]  ldst [4];
    logic [2:0]  rtype [4];
    logic [39:0] pc [4];
    logic [31:0] inst [4];
    logic [63:0] wdata [4];
    logic [2:0]  csr_cmd = 3'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [63:0] csr_wdata = 64'd0;
    logic        out_ready = 1'b0;

    logic        out_valid, out_csr_valid, overflow;
    logic [63:0] out_seq, out_wdata, out_csr_wdata;
    logic [39:0] out_pc;
    logic [31:0] out_inst, drop_cnt;
    logic [4:0]  out_ldst, fifo_level;
    logic [2:0]  out_rtype;
    logic [11:0] out_csr_addr;

    commit_trace_serializer #(.DEPTH(DEPTH), .XLEN(XLEN), .ADDR_BITS(ADDR_BITS)) dut (
        .clock(clock), .reset(reset),
        .commit_arch_valids_0(v[0]), .commit_arch_valids_1(v[1]),
        .commit_arch_valids_2(v[2]), .commit_arch_valids_3(v[3]),
        .commit_uops_0_ldst(ldst[0]), .commit_uops_1_ldst(ldst[1]),
        .commit_uops_2_ldst(ldst[2]), .commit_uops_3_ldst(ldst[3]),
        .commit_uops_0_dst_rtype(rtype[0]), .commit_uops_1_dst_rtype(rtype[1]),
        .commit_uops_2_dst_rtype(rtype[2]), .commit_uops_3_dst_rtype(rtype[3]),
        .commit_uops_0_debug_pc(pc[0]), .commit_uops_1_debug_pc(pc[1]),
        .commit_uops_2_debug_pc(pc[2]), .commit_uops_3_debug_pc(pc[3]),
        .commit_uops_0_debug_inst(inst[0]), .commit_uops_1_debug_inst(inst[1]),
        .commit_uops_2_debug_inst(inst[2]), .commit_uops_3_debug_inst(inst[3]),
        .commit_uops_0_debug_wdata(wdata[0]), .commit_uops_1_debug_wdata(wdata[1]),
        .commit_uops_2_debug_wdata(wdata[2]), .commit_uops_3_debug_wdata(wdata[3]),
        .csrwr_cmd(csr_cmd), .csrwr_addr(csr_addr), .csrwr_wdata(csr_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
        .out_pc(out_pc), .out_inst(out_inst), .out_ldst(out_ldst),
        .out_rtype(out_rtype), .out_wdata(out_wdata),
        .out_csr_valid(out_csr_valid), .out_csr_addr(out_csr_addr),
        .out_csr_wdata(out_csr_wdata),
        .overflow(overflow), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] pc;
        logic [31:0] inst;
        logic [4:0]  ldst;
        logic [2:0]  rtype;
        logic [63:0] wdata;
        logic [63:0] seq;
        logic        cv;
        logic [11:0] ca;
        logic [63:0] cd;
    } ent_t;

    ent_t    mq[$];
    longint  m_seq;
    longint  m_drop;
    bit      m_ovf;
    int      tests = 0;
    int      fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
        check("fifo_level", {59'd0, fifo_level}, 64'(mq.size()));
        check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        check("drop_cnt", {32'd0, drop_cnt}, 64'(m_drop));
        if (mq.size() != 0) begin
            check("out_pc", {24'd0, out_pc}, {24'd0, mq[0].pc});
            check("out_inst", {32'd0, out_inst}, {32'd0, mq[0].inst});
            check("out_ldst", {59'd0, out_ldst}, {59'd0, mq[0].ldst});
            check("out_rtype", {61'd0, out_rtype}, {61'd0, mq[0].rtype});
            check("out_wdata", out_wdata, mq[0].wdata);
            check("out_seq", out_seq, mq[0].seq);
            check("out_csr_valid", {63'd0, out_csr_valid}, {63'd0, mq[0].cv});
            check("out_csr_addr", {52'd0, out_csr_addr}, {52'd0, mq[0].ca});
            check("out_csr_wdata", out_csr_wdata, mq[0].cd);
        end else begin
            check("empty_pc", {24'd0, out_pc}, 64'd0);
            check("empty_csr_valid", {63'd0, out_csr_valid}, 64'd0);
        end
    endtask

    // Reference model step from the rules: all-or-nothing admission with pop credit.
    task automatic cycle();
        bit   pop;
        int   n;
        int   free;
        ent_t e;
        pop  = (mq.size() != 0) && out_ready;
        n    = int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
        free = DEPTH - mq.size() + (pop ? 1 : 0);
        if (pop) void'(mq.pop_front());
        if (n > 0 && n <= free) begin
            for (int k = 0; k < 4; k++) begin
                if (v[k]) begin
                    e.pc = pc[k]; e.inst = inst[k]; e.ldst = ldst[k];
                    e.rtype = rtype[k]; e.wdata = wdata[k]; e.seq = 64'(m_seq);
                    e.cv = 1'b0; e.ca = 12'd0; e.cd = 64'd0;
                    mq.push_back(e);
                    m_seq++;
                end
            end
`ifdef COMMIT_TRACE_CSR_EN
            if (csr_cmd != 3'd0) begin
                mq[mq.size()-1].cv = 1'b1;
                mq[mq.size()-1].ca = csr_addr;
                mq[mq.size()-1].cd = csr_wdata;
            end
`endif
        end else if (n > 0) begin
            m_ovf  = 1'b1;
            m_drop = m_drop + n;
            if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
        end
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        mq.delete();
        m_seq = 0; m_drop = 0; m_ovf = 1'b0;
        check_all();
        #2;
        reset = 1'b1;
    endtask

    task automatic rand_slots();
        for (int k = 0; k < 4; k++) begin
            pc[k]    = 40'({$urandom, $urandom});
            inst[k]  = $urandom;
            ldst[k]  = 5'($urandom);
            rtype[k] = 3'($urandom);
            wdata[k] = {$urandom, $urandom};
        end
    endtask

    initial begin
        m_seq = 0; m_drop = 0; m_ovf = 1'b0;
        rand_slots();
        #3;
        do_reset();

        // Single retire
        v = 4'b0001; pc[0] = 40'h80000000; out_ready = 1'b1;
        cycle();
        check("single_pc_const", {24'd0, out_pc}, 64'h80000000);
        check("single_seq_const", out_seq, 64'd0);
        v = 4'b0000;
        cycle();
        check("single_drained", {63'd0, out_valid}, 64'd0);

        // Gapped group
        do_reset();
        rand_slots();
        v = 4'b1010; pc[1] = 40'h104; pc[3] = 40'h10C;
        cycle();
        check("gap_first_pc", {24'd0, out_pc}, 64'h104);
        v = 4'b0000;
        cycle();
        check("gap_second_pc", {24'd0, out_pc}, 64'h10C);
        check("gap_second_seq", out_seq, 64'd1);
        cycle();

        // Fill to full, then push one with a pop credit
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_slots(); v = 4'b1111; cycle();
        end
        check("full_level_const", {59'd0, fifo_level}, 64'd16);
        rand_slots(); v = 4'b0100; out_ready = 1'b1;
        cycle();
        check("full_push_level", {59'd0, fifo_level}, 64'd16);
        check("full_push_no_ovf", {63'd0, overflow}, 64'd0);

        // Backpressure hold then in-order drain
        v = 4'b0000; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) cycle();

        // Sustained 4-wide commits
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_slots(); v = 4'b1111; cycle();
        end
        check("sustain_ovf", {63'd0, overflow}, 64'd1);
        check("sustain_drop", {32'd0, drop_cnt}, 64'd12);
        v = 4'b0000;
        for (int i = 0; i < 17; i++) cycle();

`ifdef COMMIT_TRACE_CSR_EN
        // CSR attaches to youngest slot only
        do_reset();
        rand_slots();
        v = 4'b0101; csr_cmd = 3'd1; csr_addr = 12'h300; csr_wdata = 64'h8; out_ready = 1'b0;
        cycle();
        check("csr_slot0_clear", {63'd0, out_csr_valid}, 64'd0);
        v = 4'b0000; csr_cmd = 3'd0; out_ready = 1'b1;
        cycle();
        check("csr_slot2_valid", {63'd0, out_csr_valid}, 64'd1);
        check("csr_slot2_addr", {52'd0, out_csr_addr}, 64'h300);
        check("csr_slot2_wdata", out_csr_wdata, 64'h8);
        cycle();
`endif

        // Randomized traffic with alternating drain pressure
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rand_slots();
            v         = 4'($urandom);
            csr_cmd   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            csr_addr  = 12'($urandom);
            csr_wdata = {$urandom, $urandom};
            out_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
            cycle();
        end

        // Mid-stream reset discards everything immediately
        out_ready = 1'b0;
        rand_slots(); v = 4'b1111; cycle();
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        do_reset();
        check("mid_reset_valid", {63'd0, out_valid}, 64'd0);
        v = 4'b0000;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
